forward_arbiter: RTL

FORWARD_ARBITER -- requirements
Module: forward_arbiter

---
 rtl/xbar_pkg.sv | 14 +
 rtl/rr_priority_picker.sv | 27 ++
 rtl/forward_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: arbiter state encoding and the NO_GRANT constant.
package xbar_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // All-ones pattern of the given width; callers cast to their grant width.
    function automatic logic [31:0] no_grant(input int unsigned width);
        return (32'h1 << width) - 32'h1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request after last_master, wrapping.
module rr_priority_picker #(
    parameter int masters = 2,
    parameter int mw      = (masters > 1) ? $clog2(masters) : 1
) (
    input  logic [masters-1:0] request,
    input  logic [mw-1:0]      last_master,
    output logic [mw-1:0]      winner,
    output logic               any_valid
);

    always_comb begin
        int idx;
        idx       = 0;
        winner    = '0;
        any_valid = 1'b0;
        // last_master itself is visited last, so it only wins as the sole requester.
        for (int k = 1; k <= masters; k++) begin
            idx = (int'(last_master) + k) % masters;
            if (!any_valid && request[idx]) begin
                any_valid = 1'b1;
                winner    = mw'(idx);
            end
        end
    end

endmodule

// File: rtl/forward_arbiter.sv
// Per-slave forward arbiter: round-robin grant of master FIFO heads into this slave's FIFO.
// Define XBAR_FWD_ARB_BACK2BACK_EN to re-grant on the transfer edge (no NO_GRANT bubble).
module forward_arbiter
    import xbar_pkg::*;
#(
    parameter int masters           = 2,
    parameter int slaves            = 2,
    parameter int i_am_slave_number = 0
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic [0:masters-1]         master_fifo_empty,
    input  logic [$clog2(slaves)-1:0]  master_dest_slave [0:masters-1],
    input  logic                       slave_fifo_full,
    output logic [$clog2(masters):0]   grant_master_number,
    output logic                       push_to_fifo
);

    localparam int SW = $clog2(slaves);
    localparam int MW = (masters > 1) ? $clog2(masters) : 1;
    localparam int GW = $clog2(masters) + 1;
    localparam int NP = 1 << MW;
    localparam logic [GW-1:0] NO_GRANT = GW'(no_grant(GW));
    localparam logic [SW-1:0] MY_SLAVE = SW'(i_am_slave_number);
    localparam logic [MW-1:0] LAST_RST = MW'(masters - 1);

    arb_state_t    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [MW-1:0] last_q, last_d;

    logic [masters-1:0] request;
    logic [NP-1:0]      req_pad;
    logic [MW-1:0]      grant_idx;
    logic               req_g;
    logic [MW-1:0]      pick_last;
    logic [MW-1:0]      winner;
    logic               any_valid;

    always_comb begin
        request = '0;
        for (int i = 0; i < masters; i++) begin
            request[i] = ~master_fifo_empty[i] & (master_dest_slave[i] == MY_SLAVE);
        end
    end

    // Zero-padded so the grant index never selects beyond the vector.
    assign req_pad   = NP'(request);
    assign grant_idx = grant_q[MW-1:0];
    assign req_g     = req_pad[grant_idx];

    // In GRANT the picker only matters on a transfer, when the served master becomes last.
    assign pick_last = (state_q == GRANT) ? grant_idx : last_q;

    rr_priority_picker #(
        .masters (masters),
        .mw      (MW)
    ) u_picker (
        .request     (request),
        .last_master (pick_last),
        .winner      (winner),
        .any_valid   (any_valid)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            grant_q <= NO_GRANT;
            last_q  <= LAST_RST;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        grant_d             = grant_q;
        last_d              = last_q;
        grant_master_number = NO_GRANT;
        push_to_fifo        = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d = GRANT;
                    grant_d = GW'(winner);
                end
            end
            GRANT: begin
                grant_master_number = grant_q;
                push_to_fifo        = req_g & ~slave_fifo_full;
                if (!req_g) begin
                    // Head withdrawn: drop the grant without touching fairness state.
                    state_d = IDLE;
                    grant_d = NO_GRANT;
                end else if (push_to_fifo) begin
                    last_d = grant_idx;
`ifdef XBAR_FWD_ARB_BACK2BACK_EN
                    if (any_valid) begin
                        grant_d = GW'(winner);
                    end else begin
                        state_d = IDLE;
                        grant_d = NO_GRANT;
                    end
`else
                    state_d = IDLE;
                    grant_d = NO_GRANT;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = NO_GRANT;
            end
        endcase
    end

endmodule
